// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the future receiver.
//   - uart_state_e : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   - PAR_EVEN / PAR_ODD   : parity type encodings on i_par_typ
//   - START_BIT / STOP_BIT : line levels of the framing bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_parity_calc.sv
// -----------------------------------------------------------------------------
// uart_parity_calc
// Combinational parity generator, shared by the transmitter (generation) and
// the receiver (checking).
// Ports:
//   i_data     [DATA_WIDTH-1:0]  data word
//   i_par_typ  1                 PAR_EVEN or PAR_ODD
//   o_parity   1                 parity bit to place on the line
// -----------------------------------------------------------------------------
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    logic w_xor;

    assign w_xor = ^i_data;

    // Even parity makes the total count of ones even, so the bit equals the
    // XOR of the data; odd parity is its inverse.
    assign o_parity = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule : uart_parity_calc

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter clocked by the divided baud clock (one cycle = one bit).
// Serialises a parallel word as: start bit, data LSB first, optional parity,
// stop bit. Outputs are registered; o_tx idles high.
//
// Optional feature macro: UART_TX_TWO_STOP_EN
//   When defined, adds input i_stop2 (latched at acceptance). A latched 1
//   stretches STOP to two bit times. When undefined, one stop bit always.
//
// Ports:
//   i_clk         1           divided baud clock
//   i_rst         1           asynchronous, active-high reset
//   i_data        DATA_WIDTH  word to transmit
//   i_data_valid  1           word valid; accepted only while o_busy=0
//   i_par_en      1           1 = append parity bit
//   i_par_typ     1           0 = even, 1 = odd parity
//   i_stop2       1           (UART_TX_TWO_STOP_EN only) 1 = two stop bits
//   o_tx          1           serial line
//   o_busy        1           frame in progress
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  i_stop2,
`endif
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    uart_state_e           r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_parity;
    logic                  w_stop_extend;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (i_data),
        .i_par_typ (i_par_typ),
        .o_parity  (w_parity)
    );

`ifdef UART_TX_TWO_STOP_EN
    logic r_stop2;
    logic r_stop_second;

    // Stay in STOP one more cycle only on the first STOP cycle of a
    // two-stop-bit frame.
    assign w_stop_extend = r_stop2 & ~r_stop_second;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
        end else begin
            if (r_state == IDLE && i_data_valid) begin
                r_stop2 <= i_stop2;
            end
            if (r_state == STOP && w_stop_extend) begin
                r_stop_second <= 1'b1;
            end else if (r_state != STOP) begin
                r_stop_second <= 1'b0;
            end
        end
    end
`else
    assign w_stop_extend = 1'b0;
`endif

    // The registered output is loaded with the level of the state being
    // entered, so o_tx changes on the same edge as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= STOP_BIT;
                    r_busy <= 1'b0;
                    if (i_data_valid) begin
                        r_shift   <= i_data;
                        r_par_en  <= i_par_en;
                        r_par_bit <= w_parity;
                        r_cnt     <= '0;
                        r_tx      <= START_BIT;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end

                START: begin
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_cnt   <= '0;
                    r_state <= DATA;
                end

                DATA: begin
                    // r_tx currently holds data bit r_cnt.
                    if (r_cnt == CNT_LAST) begin
                        if (r_par_en) begin
                            r_tx    <= r_par_bit;
                            r_state <= PARITY;
                        end else begin
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
                        end
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end

                PARITY: begin
                    r_tx    <= STOP_BIT;
                    r_state <= STOP;
                end

                STOP: begin
                    r_tx <= STOP_BIT;
                    if (w_stop_extend) begin
                        r_busy <= 1'b1;
                    end else begin
                        // Always pass through one IDLE cycle; valid is not
                        // looked at here so frames are separated by a gap.
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;

endmodule : uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the UART system.
- Clocked directly by the divided baud-rate clock from the programmable clock divider, so one clock cycle is one bit time.
- Accepts a parallel data word with a valid strobe and serialises it onto the TX line as: start bit, data bits LSB first, optional parity bit, stop bit.
- Reports frame-in-progress to the upstream data source/FIFO.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- i_clk  input  1  divided baud clock; one cycle = one bit period
- i_rst  input  1  asynchronous, active-high reset
- i_data  input  DATA_WIDTH  parallel word to transmit
- i_data_valid  input  1  word on i_data is valid; accepted only while o_busy=0
- i_par_en  input  1  1 = append parity bit
- i_par_typ  input  1  0 = even parity, 1 = odd parity
- o_tx  output  1  serial TX line; idles high
- o_busy  output  1  frame in progress; high from cycle after acceptance until frame completes

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: o_tx=1, o_busy=0, FSM=IDLE, shift register/bit counter/latched config all 0.
- Outputs: o_tx and o_busy are registered, with no combinational path from inputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1. On an edge with i_data_valid=1, latch i_data, i_par_en, i_par_typ and the computed parity bit, then go to START.
  - START: o_tx=0 for 1 cycle, then go to DATA with bit counter=0.
  - DATA: o_tx=shift_reg[0], shift right each cycle. After DATA_WIDTH cycles (counter = DATA_WIDTH-1), go to PARITY if latched par_en=1, else STOP.
  - PARITY: o_tx=latched parity for 1 cycle, then go to STOP.
  - STOP: o_tx=1 for 1 cycle, then go to IDLE.
- Timing, with E0 = accepting edge:
  - after E0: o_tx=0, o_busy=1.
  - after E1..E_DATA_WIDTH: data bits.
  - then parity (if enabled), then stop.
  - the next edge returns to IDLE with o_busy=0.
  - Frame = DATA_WIDTH+2 bit times (+1 with parity).
- Parity: even = XOR of all data bits; odd = inverted XOR. Computed from i_data at acceptance.
- Back-to-back: i_data_valid is ignored while o_busy=1, including during STOP. There is a minimum of 1 idle-high cycle between frames. A valid held continuously starts the next frame on the first IDLE edge.
- Config stability: changes to i_data, i_par_en or i_par_typ mid-frame have no effect on the current frame.
- Reset mid-frame: immediately o_tx=1, o_busy=0, IDLE. The partial frame is dropped, and no stop bit is emitted beyond o_tx=1.
- Bit counter width: $clog2(DATA_WIDTH). It never wraps within DATA.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: adds input i_stop2 (1 bit), latched at acceptance. When latched 1, STOP lasts 2 cycles (o_tx=1, o_busy=1 for both), adding 1 bit time to the frame.
- Undefined: port i_stop2 absent; exactly one stop bit always.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum/localparams: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - These are shared with the future uart_rx.
- Sub-module uart_parity_calc (combinational, parameter DATA_WIDTH): data + par_typ in, parity bit out. Reused by uart_rx for its parity check.

Test Plan:
- 0xA5, par_en=1, even: o_tx after E0..E10 = 0,1,0,1,0,0,1,0,1,0(parity),1. o_busy high 11 cycles, low after E11.
- 0xA5, par_en=1, odd: identical, except the parity bit = 1.
- 0x3C, par_en=0: o_tx = 0,0,0,1,1,1,1,0,0,1. o_busy low after E10 (10-cycle frame).
- i_data_valid held high with 0x55 then 0xAA: second start bit appears exactly 1 idle-high cycle after the first stop bit. A pulse with 0xFF mid-frame is ignored, and only 0x55/0xAA are transmitted.
- i_rst asserted during data bit 4: o_tx=1 and o_busy=0 asynchronously. After release, a new 0x81 frame transmits correctly from the start bit.
- With UART_TX_TWO_STOP_EN and i_stop2=1, 0x00, par_en=0: o_tx = 0, eight 0s, 1, 1. o_busy low after 11 cycles.
